// File: rtl/paralelo_serial_tx_pkg.sv
// Shared PHY constants for the parallel-to-serial transmitter and its receiver.
package paralelo_serial_tx_pkg;

  // Idle / training character; the receiver counts these to reach lock.
  localparam logic [7:0] PHY_COMMA = 8'hBC;

  // Line symbol width and the word layout {valid, data[7:0]}.
  localparam int unsigned SYM_W     = 2;
  localparam int unsigned WORD_W    = 9;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned VALID_BIT = 8;

  // Smallest training burst that still carries the receiver's comma counter past 4.
  localparam int unsigned MIN_SYNC  = 5;

  // Symbols per word; the phase counter is sized for exactly four.
  localparam int unsigned PHASES    = DATA_W / SYM_W;

  typedef enum logic {
    ST_SYNC,
    ST_RUN
  } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: sends a comma training burst after reset,
// then emits one 9-bit {valid, data} word as four 2-bit symbols (MSB pair first).
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
#(
  parameter int unsigned N_SYNC = 6,
  parameter logic [7:0]  COMMA  = PHY_COMMA
) (
  input  logic              clk16,
  input  logic              reset16,
  input  logic [WORD_W-1:0] in_paralelo,
  output logic              in_ready,
  output logic [SYM_W-1:0]  serial,
  output logic              synced,
  output logic              comma_collision
);

  localparam int unsigned   CNT_W     = $clog2(N_SYNC + 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(N_SYNC - 1);
  localparam logic [CNT_W-1:0] SYNC_FULL = CNT_W'(N_SYNC);

  tx_state_e         state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  sync_cnt_q, sync_cnt_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              synced_q, synced_d;
  logic              coll_q, coll_d;
  logic              accept;

  // A word is taken only on the last symbol slot once training is done.
  always_comb begin
    accept = (state_q == ST_RUN) && (phase_q == 2'd3);
  end

  // Next-state logic: phase counter, training count and the word register.
  // in_paralelo is read only inside the accept branch so unknowns outside
  // accept cycles never reach the shift register.
  always_comb begin
    phase_d    = phase_q + 2'd1;
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    sreg_d     = sreg_q;
    synced_d   = synced_q;
    coll_d     = 1'b0;
    if (phase_q == 2'd3) begin
      case (state_q)
        ST_SYNC: begin
          sreg_d = COMMA;
          if (sync_cnt_q != SYNC_FULL) begin
            sync_cnt_d = sync_cnt_q + 1'b1;
          end
          if (sync_cnt_q == SYNC_LAST) begin
            state_d  = ST_RUN;
            synced_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (in_paralelo[VALID_BIT]) begin
            sreg_d = in_paralelo[DATA_W-1:0];
            coll_d = (in_paralelo[DATA_W-1:0] == COMMA);
          end else begin
            sreg_d = COMMA;
          end
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk16 or posedge reset16) begin
    if (reset16) begin
      state_q    <= ST_SYNC;
      phase_q    <= '0;
      sync_cnt_q <= '0;
      sreg_q     <= COMMA;
      synced_q   <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sync_cnt_q <= sync_cnt_d;
      sreg_q     <= sreg_d;
      synced_q   <= synced_d;
      coll_q     <= coll_d;
    end
  end

  // Four-way symbol select: MSB pair at phase 0 down to LSB pair at phase 3.
  always_comb begin
    serial = '0;
    case (phase_q)
      2'd0:    serial = sreg_q[7:6];
      2'd1:    serial = sreg_q[5:4];
      2'd2:    serial = sreg_q[3:2];
      default: serial = sreg_q[1:0];
    endcase
  end

  assign in_ready        = accept;
  assign synced          = synced_q;
  assign comma_collision = coll_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx against a word-level model of the line.
module tb_paralelo_serial_tx;

  localparam int unsigned N_SYNC = 6;
  localparam logic [7:0]  K      = 8'hBC;

  logic       clk16;
  logic       reset16;
  logic [8:0] in_paralelo;
  logic       in_ready;
  logic [1:0] serial;
  logic       synced;
  logic       comma_collision;

  paralelo_serial_tx #(.N_SYNC(N_SYNC), .COMMA(K)) dut (
    .clk16          (clk16),
    .reset16        (reset16),
    .in_paralelo    (in_paralelo),
    .in_ready       (in_ready),
    .serial         (serial),
    .synced         (synced),
    .comma_collision(comma_collision)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  int unsigned c;
  int          n_vec;
  int          n_err;
  logic [7:0]  acc_data[$];
  bit          acc_valid[$];
  logic [8:0]  stim_q[$];
  logic [7:0]  rx_shift;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  // Words on the line: N_SYNC+1 commas, then one word per accept slot.
  function automatic logic [7:0] exp_word(input int unsigned cyc);
    int unsigned w;
    int unsigned k;
    w = cyc / 4;
    if (w <= N_SYNC) return K;
    k = w - N_SYNC - 1;
    if (k >= acc_data.size()) return K;
    return acc_valid[k] ? acc_data[k] : K;
  endfunction

  function automatic bit exp_valid_char(input int unsigned cyc);
    int unsigned w;
    int unsigned k;
    w = cyc / 4;
    if (w <= N_SYNC) return 1'b0;
    k = w - N_SYNC - 1;
    if (k >= acc_data.size()) return 1'b0;
    return acc_valid[k] && (acc_data[k] == K);
  endfunction

  function automatic logic [1:0] sym(input logic [7:0] w, input int unsigned p);
    return 2'((w >> (6 - 2 * p)) & 8'd3);
  endfunction

  // One clock cycle: drive input, sample at the falling edge, update the model.
  task automatic step(input bit rnd);
    logic [8:0] v;
    logic [7:0] w8;
    bit         acc;
    bit         rx_v;
    int unsigned p;
    acc = ((c % 4) == 3) && (c >= 4 * N_SYNC);
    if (acc) begin
      if (stim_q.size() != 0) v = stim_q.pop_front();
      else if (rnd) begin
        v[8]   = 1'($urandom_range(0, 1));
        v[7:0] = ($urandom_range(0, 7) == 0) ? K : 8'($urandom);
      end else v = {1'b0, 8'($urandom)};
    end else begin
      v = 9'($urandom);
    end
    in_paralelo = v;
    #4;
    p  = c % 4;
    w8 = exp_word(c);
    check("serial", 32'(serial), 32'(sym(w8, p)));
    check("in_ready", 32'(in_ready), 32'(acc));
    check("synced", 32'(synced), 32'(c >= 4 * N_SYNC));
    check("comma_collision", 32'(comma_collision), 32'((p == 0) && exp_valid_char(c)));
    rx_shift = {rx_shift[5:0], serial};
    if (p == 3) begin
      rx_v = (c / 4 > N_SYNC) && acc_valid[c / 4 - N_SYNC - 1] && (w8 != K);
      check("rx_word", {23'd0, (rx_shift != K), rx_shift}, {23'd0, rx_v, w8});
    end
    if (acc) begin
      acc_valid.push_back(v[8]);
      acc_data.push_back(v[7:0]);
    end
    @(posedge clk16);
    #1;
    c++;
  endtask

  task automatic run(input int unsigned n, input bit rnd);
    for (int unsigned i = 0; i < n; i++) step(rnd);
  endtask

  task automatic release_reset();
    reset16 = 1'b0;
    c = 0;
    acc_data.delete();
    acc_valid.delete();
    stim_q.delete();
    rx_shift = '0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    c           = 0;
    rx_shift    = '0;
    reset16     = 1'b1;
    in_paralelo = '0;
    @(posedge clk16);
    @(posedge clk16);
    #1;
    check("rst_serial", 32'(serial), 32'h2);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_synced", 32'(synced), 32'h0);
    check("rst_collision", 32'(comma_collision), 32'h0);
    release_reset();

    // Training burst and idle comma fill.
    run(40, 1'b0);
    // Single data word, then idle.
    stim_q.push_back({1'b1, 8'hA5});
    run(12, 1'b0);
    // Back-to-back words.
    stim_q.push_back({1'b1, 8'h00});
    stim_q.push_back({1'b1, 8'hFF});
    stim_q.push_back({1'b1, 8'h3C});
    run(16, 1'b0);
    // Valid word equal to the comma.
    stim_q.push_back({1'b1, K});
    run(12, 1'b0);

    // Reset in the middle of a data word (phase 2).
    stim_q.push_back({1'b1, 8'h4D});
    while ((c % 4) != 3) step(1'b0);
    run(3, 1'b0);
    check("pre_rst_serial", 32'(serial), 32'(sym(exp_word(c), 2)));
    #1;
    reset16 = 1'b1;
    #1;
    check("async_rst_serial", 32'(serial), 32'h2);
    check("async_rst_synced", 32'(synced), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk16);
    @(posedge clk16);
    #1;
    release_reset();
    run(36, 1'b0);

    // Random traffic, roughly 200 words.
    run(800, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
